// File: rtl/fifo_pkg.sv
// fifo_pkg: shared skid-buffer occupancy encoding and default word width
package fifo_pkg;
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} occ_t;
    localparam int DEF_WORDSIZE = 8;
endpackage

// File: rtl/skid_buf.sv
// skid_buf: 2-entry register pair with occupancy FSM, registered valid/ready output
// ports: rclk/rst (async active-low) | push, push_data: word entering this cycle
//        out_ready: consumer ready | out_data, out_valid: registered stream | full: both entries held
module skid_buf import fifo_pkg::*; #(
    parameter int WORDSIZE = DEF_WORDSIZE
) (
    input  logic                rclk,
    input  logic                rst,
    input  logic                push,
    input  logic [WORDSIZE-1:0] push_data,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] out_data,
    output logic                out_valid,
    output logic                full
);
    occ_t state, state_nxt;
    logic [WORDSIZE-1:0] skid;
    logic deliver;
    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= state_nxt != S_EMPTY;
        end
    end
    always_comb begin
        state_nxt = state == S_EMPTY ? (push ? S_ONE : S_EMPTY) :
                    state == S_ONE   ? (push == deliver ? S_ONE : push ? S_TWO : S_EMPTY) :
                                       (deliver ? S_ONE : S_TWO);
    end
    always_comb begin
        deliver = out_valid && out_ready;
        full    = state == S_TWO;
    end
    // main reloads on delivery (from skid when two are held) or when filling from empty;
    // skid only catches a pop that main cannot take because it is still stalled
    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            out_data <= '0;
            skid     <= '0;
        end else begin
            if (deliver ? (push || state == S_TWO) : (push && state == S_EMPTY))
                out_data <= state == S_TWO ? skid : push_data;
            if (push && !deliver && state == S_ONE)
                skid <= push_data;
        end
    end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a show-ahead FIFO read port into a registered valid/ready stream
// ports: rclk/rst (async active-low) | empty, read_data: FIFO head | signal_read: FIFO pop
//        out_data, out_valid, out_ready: stream | word_count: deliveries (FIFO_RD_CNT_EN only)
module fifo_rd_stream import fifo_pkg::*; #(
    parameter int WORDSIZE = DEF_WORDSIZE
`ifdef FIFO_RD_CNT_EN
    , parameter int CNTSIZE = 16
`endif
) (
    input  logic                rclk,
    input  logic                rst,
    input  logic                empty,
    input  logic [WORDSIZE-1:0] read_data,
    output logic                signal_read,
    output logic [WORDSIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready
`ifdef FIFO_RD_CNT_EN
    , output logic [CNTSIZE-1:0] word_count
`endif
);
    logic full;
    // pop whenever a slot is free; reset masks the strobe so the FIFO never advances in reset
    assign signal_read = rst && !empty && !full;
    skid_buf #(.WORDSIZE(WORDSIZE)) u_skid (
        .rclk      (rclk),
        .rst       (rst),
        .push      (signal_read),
        .push_data (read_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .full      (full)
    );
`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge rclk or negedge rst) begin
        if (!rst)
            word_count <= '0;
        else if (out_valid && out_ready)
            word_count <= word_count + CNTSIZE'(1);
    end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized self-checking bench against a queue model of FIFO + stream
module tb_fifo_rd_stream;
    localparam int W = 8;
`ifdef FIFO_RD_CNT_EN
    localparam int CW = 4;
    logic [CW-1:0] word_count;
`endif
    logic rclk = 1'b0;
    logic rst, empty, signal_read, out_valid, out_ready;
    logic [W-1:0] read_data, out_data;

    fifo_rd_stream #(
        .WORDSIZE(W)
`ifdef FIFO_RD_CNT_EN
        , .CNTSIZE(CW)
`endif
    ) dut (
        .rclk        (rclk),
        .rst         (rst),
        .empty       (empty),
        .read_data   (read_data),
        .signal_read (signal_read),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
`ifdef FIFO_RD_CNT_EN
        , .word_count (word_count)
`endif
    );

    always #5 rclk = ~rclk;

    logic [W-1:0] src[$];
    logic [W-1:0] pend[$];
    logic gate;
    int vectors = 0, errors = 0, delivered = 0, pops = 0;
    logic obs_sr, obs_v, exp_sr, exp_v;
    logic [W-1:0] obs_d, exp_d;
    logic [31:0] obs_wc, exp_wc;

    // one rclk cycle: present FIFO head, sample outputs, predict, then advance the model
    task automatic tick();
        empty = gate || src.size() == 0;
        read_data = empty ? '0 : src[0];
        #1;
        obs_sr = signal_read;
        obs_v = out_valid;
        obs_d = out_data;
`ifdef FIFO_RD_CNT_EN
        obs_wc = 32'(word_count);
        exp_wc = delivered & ((1 << CW) - 1);
`else
        obs_wc = 0;
        exp_wc = 0;
`endif
        exp_sr = rst && !empty && pend.size() < 2;
        exp_v = pend.size() > 0;
        exp_d = exp_v ? pend[0] : '0;
        @(posedge rclk);
        #1;
        if (exp_v && out_ready) begin
            void'(pend.pop_front());
            delivered++;
        end
        if (exp_sr) begin
            pend.push_back(src.pop_front());
            pops++;
        end
        @(negedge rclk);
    endtask

    task automatic test_reset();
        empty = 1'b0;
        read_data = 8'hAA;
        #1;
        vectors++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL reset_out: got v=%b d=%h want v=0 d=00", out_valid, out_data); end
        vectors++; if (signal_read !== 1'b0) begin errors++; $display("FAIL reset_sr: got %b want 0", signal_read); end
`ifdef FIFO_RD_CNT_EN
        vectors++; if (word_count !== '0) begin errors++; $display("FAIL reset_wc: got %0d want 0", word_count); end
`endif
        @(negedge rclk);
        rst = 1'b1;
        gate = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (obs_sr !== 1'b0 || obs_v !== 1'b0) begin errors++; $display("FAIL reset_idle: got sr=%b v=%b want 0 0", obs_sr, obs_v); end
        end
    endtask

    task automatic test_stream();
        int nv = 0;
        for (int i = 0; i < 8; i++) src.push_back(W'(8'h11 + i));
        gate = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (obs_v) nv++;
            vectors++; if (obs_sr !== exp_sr) begin errors++; $display("FAIL stream_sr: got %b want %b", obs_sr, exp_sr); end
            vectors++; if (obs_v !== exp_v || (exp_v && obs_d !== exp_d)) begin errors++; $display("FAIL stream_out: got v=%b d=%h want v=%b d=%h", obs_v, obs_d, exp_v, exp_d); end
            vectors++; if (obs_wc !== exp_wc) begin errors++; $display("FAIL stream_wc: got %0d want %0d", obs_wc, exp_wc); end
        end
        vectors++; if (nv != 8 || delivered != 8) begin errors++; $display("FAIL stream_count: got valid=%0d delivered=%0d want 8 8", nv, delivered); end
`ifdef FIFO_RD_CNT_EN
        vectors++; if (word_count !== CW'(8)) begin errors++; $display("FAIL stream_wc_end: got %0d want 8", word_count); end
`endif
    endtask

    task automatic test_backpressure();
        int d0 = delivered;
        pops = 0;
        for (int i = 0; i < 5; i++) src.push_back(W'(8'h11 + i));
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++; if (obs_sr !== exp_sr) begin errors++; $display("FAIL bp_sr: got %b want %b", obs_sr, exp_sr); end
            vectors++; if (obs_v !== exp_v || (exp_v && obs_d !== exp_d)) begin errors++; $display("FAIL bp_out: got v=%b d=%h want v=%b d=%h", obs_v, obs_d, exp_v, exp_d); end
        end
        vectors++; if (pops != 2 || out_data !== 8'h11) begin errors++; $display("FAIL bp_hold: got pops=%0d d=%h want 2 11", pops, out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++; if (obs_sr !== exp_sr) begin errors++; $display("FAIL bp_release_sr: got %b want %b", obs_sr, exp_sr); end
            vectors++; if (obs_v !== exp_v || (exp_v && obs_d !== exp_d)) begin errors++; $display("FAIL bp_release_out: got v=%b d=%h want v=%b d=%h", obs_v, obs_d, exp_v, exp_d); end
        end
        vectors++; if (delivered - d0 != 5) begin errors++; $display("FAIL bp_total: got %0d want 5", delivered - d0); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) src.push_back(W'(8'h21 + i));
        gate = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        vectors++; if (out_valid !== 1'b1 || pend.size() != 2) begin errors++; $display("FAIL mid_pre: got v=%b occ=%0d want 1 2", out_valid, pend.size()); end
        rst = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || signal_read !== 1'b0) begin errors++; $display("FAIL mid_reset: got v=%b sr=%b want 0 0", out_valid, signal_read); end
`ifdef FIFO_RD_CNT_EN
        vectors++; if (word_count !== '0) begin errors++; $display("FAIL mid_reset_wc: got %0d want 0", word_count); end
`endif
        pend.delete();
        src.delete();
        delivered = 0;
        gate = 1'b1;
        @(negedge rclk);
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (obs_sr !== 1'b0 || obs_v !== 1'b0) begin errors++; $display("FAIL mid_after: got sr=%b v=%b want 0 0", obs_sr, obs_v); end
        end
    endtask

    task automatic test_alternating();
        int d0 = delivered;
        int p0 = pops;
        gate = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 150; i++) begin
            out_ready = ~out_ready;
            if (src.size() < 4) src.push_back(W'($urandom));
            tick();
            vectors++; if (obs_sr !== exp_sr) begin errors++; $display("FAIL alt_sr: got %b want %b occ=%0d", obs_sr, exp_sr, pend.size()); end
            vectors++; if (obs_v !== exp_v || (exp_v && obs_d !== exp_d)) begin errors++; $display("FAIL alt_out: got v=%b d=%h want v=%b d=%h", obs_v, obs_d, exp_v, exp_d); end
        end
        vectors++; if ((pops - p0) - (delivered - d0) != pend.size() - 0 && pend.size() > 2) begin errors++; $display("FAIL alt_balance: got occ=%0d want <=2", pend.size()); end
    endtask

    task automatic test_underflow();
        out_ready = 1'b1;
        gate = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++; if (obs_sr !== 1'b0) begin errors++; $display("FAIL uf_sr: got %b want 0", obs_sr); end
            vectors++; if (obs_v !== exp_v || (exp_v && obs_d !== exp_d)) begin errors++; $display("FAIL uf_out: got v=%b d=%h want v=%b d=%h", obs_v, obs_d, exp_v, exp_d); end
        end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL uf_end: got v=%b want 0", out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            out_ready = $urandom_range(0, 2) != 0;
            gate = $urandom_range(0, 4) == 0;
            if (src.size() < 6 && $urandom_range(0, 3) != 0) src.push_back(W'($urandom));
            tick();
            vectors++; if (obs_sr !== exp_sr) begin errors++; $display("FAIL rnd_sr: got %b want %b", obs_sr, exp_sr); end
            vectors++; if (obs_v !== exp_v || (exp_v && obs_d !== exp_d)) begin errors++; $display("FAIL rnd_out: got v=%b d=%h want v=%b d=%h", obs_v, obs_d, exp_v, exp_d); end
            vectors++; if (obs_wc !== exp_wc) begin errors++; $display("FAIL rnd_wc: got %0d want %0d", obs_wc, exp_wc); end
        end
    endtask

`ifdef FIFO_RD_CNT_EN
    task automatic test_wrap();
        rst = 1'b0;
        pend.delete();
        src.delete();
        delivered = 0;
        @(negedge rclk);
        rst = 1'b1;
        for (int i = 0; i < 17; i++) src.push_back(W'(i));
        gate = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++; if (obs_wc !== exp_wc) begin errors++; $display("FAIL wrap_wc: got %0d want %0d", obs_wc, exp_wc); end
        end
        vectors++; if (word_count !== CW'(1) || delivered != 17) begin errors++; $display("FAIL wrap_end: got wc=%0d n=%0d want 1 17", word_count, delivered); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        gate = 1'b1;
        out_ready = 1'b0;
        empty = 1'b1;
        read_data = '0;
        #2 rst = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
        test_reset();
        test_stream();
        test_backpressure();
        test_reset_midstream();
        test_alternating();
        test_underflow();
        test_random();
`ifdef FIFO_RD_CNT_EN
        test_wrap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
